// File: rtl/rr_timeout_arbiter_if.sv
// rr_timeout_arbiter_if: request/flit-header inputs and grant/timeout outputs of the arbiter
interface rr_timeout_arbiter_if #(
  parameter int NPORTS = 5,
  parameter int LEN_W = 12,
  parameter int FID_W = 3
);
  logic [NPORTS-1:0] req;
  logic [NPORTS*FID_W-1:0] flit_id;
  logic [NPORTS*LEN_W-1:0] length;
  logic [NPORTS-1:0] grant;
  logic [NPORTS-1:0] timeout;
  modport master (output req, flit_id, length, input grant, timeout);
  modport slave (input req, flit_id, length, output grant, timeout);
endinterface

// File: rtl/rr_timeout_arbiter.sv
// rr_timeout_arbiter: round-robin arbiter whose grant tenure is bounded by a limit latched from each port's head flit
module rr_timeout_arbiter #(
  parameter int NPORTS = 5,
  parameter int LEN_W = 12,
  parameter int FID_W = 3,
  parameter int HEAD_ID = 1
) (
  input logic clk,
  input logic rst_n,
  rr_timeout_arbiter_if.slave bus
);
  localparam int IW = NPORTS > 1 ? $clog2(NPORTS) : 1;
  logic [LEN_W-1:0] limit [NPORTS];
  logic [LEN_W-1:0] count;
  logic [IW-1:0] ptr, g, base, idx;
  logic [NPORTS-1:0] grant, timeout, nxt;
  logic idle, hold, expired, found;
  assign bus.grant = grant;
  assign bus.timeout = timeout;
  assign idle = grant == '0;
  assign expired = !idle && limit[g] != '0 && count == limit[g];
  assign hold = !idle && bus.req[g] && !expired;
  assign base = idle ? ptr : g;
  // encode the one-hot grant into the index of the port holding it
  always_comb begin
    g = '0;
    for (int i = 0; i < NPORTS; i++)
      if (grant[i]) g = IW'(i);
  end
  // scan from base+1 with wrap; base itself is a candidate only when idle, so a released port yields
  always_comb begin
    nxt = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      idx = IW'((int'(base) + k) % NPORTS);
      if (!found && bus.req[idx] && (idle || k < NPORTS)) begin
        nxt[idx] = 1'b1;
        found = 1'b1;
      end
    end
    if (hold) nxt = grant;
  end
  // per-port limit follows the length of every head flit, granted or not
  always_ff @(posedge clk)
    for (int i = 0; i < NPORTS; i++)
      if (!rst_n) limit[i] <= '0;
      else if (bus.flit_id[i*FID_W +: FID_W] == FID_W'(HEAD_ID)) limit[i] <= bus.length[i*LEN_W +: LEN_W];
  // grant register, saturating tenure counter, last-grant pointer and expiry pulse
  always_ff @(posedge clk)
    if (!rst_n) begin
      grant <= '0;
      timeout <= '0;
      count <= '0;
      ptr <= IW'(NPORTS - 1);
    end else begin
      grant <= nxt;
      timeout <= (expired && bus.req[g]) ? grant : '0;
      count <= nxt == '0 ? '0 : nxt != grant ? LEN_W'(1) : count + LEN_W'(count != '1);
      if (!idle && nxt != grant) ptr <= g;
    end
endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// tb_rr_timeout_arbiter: scoreboard-driven directed checks of grant rotation, tenure expiry and reset
module tb_rr_timeout_arbiter;
  localparam int NP = 5, LW = 12, FW = 3;
  typedef struct {
    logic [NP-1:0] g;
    logic [NP-1:0] t;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0, checks = 0;
  exp_t sb[$];
  exp_t e;
  rr_timeout_arbiter_if #(.NPORTS(NP), .LEN_W(LW), .FID_W(FW)) bus ();
  rr_timeout_arbiter #(.NPORTS(NP), .LEN_W(LW), .FID_W(FW), .HEAD_ID(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;

  task automatic set_port(input int p, input logic [FW-1:0] f, input logic [LW-1:0] l);
    bus.flit_id[p*FW +: FW] = f;
    bus.length[p*LW +: LW] = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.flit_id = '0;
    bus.length = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = '1;
    do_reset();
    checks++;
    if (bus.grant !== 5'b0) begin errors++; $display("FAIL reset_grant got=%b want=%b", bus.grant, 5'b0); end
    checks++;
    if (bus.timeout !== 5'b0) begin errors++; $display("FAIL reset_timeout got=%b want=%b", bus.timeout, 5'b0); end
  endtask

  task automatic test_unlimited();
    bus.req = 5'b00001;
    for (int i = 0; i < 10; i++) sb.push_back('{5'b00001, 5'b0});
    sb.push_back('{5'b0, 5'b0});
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.grant !== e.g || bus.timeout !== e.t)
        begin errors++; $display("FAIL unlimited[%0d] grant=%b timeout=%b want grant=%b timeout=%b", i, bus.grant, bus.timeout, e.g, e.t); end
      if (i == 9) bus.req = '0;
    end
  endtask

  task automatic test_timeout();
    set_port(1, 3'd1, 12'd3);
    bus.req = 5'b00010;
    sb.push_back('{5'b00010, 5'b0});
    sb.push_back('{5'b00010, 5'b0});
    sb.push_back('{5'b00010, 5'b0});
    sb.push_back('{5'b0, 5'b00010});
    sb.push_back('{5'b00010, 5'b0});
    sb.push_back('{5'b0, 5'b0});
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.grant !== e.g || bus.timeout !== e.t)
        begin errors++; $display("FAIL timeout[%0d] grant=%b timeout=%b want grant=%b timeout=%b", i, bus.grant, bus.timeout, e.g, e.t); end
      if (i == 0) set_port(1, 3'd0, 12'd0);
      if (i == 4) bus.req = '0;
    end
  endtask

  task automatic test_rotate();
    logic [NP-1:0] oh;
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 3'd1, 12'd2);
    bus.req = '1;
    for (int i = 0; i < 12; i++) begin
      oh = 5'b00001 << ((i / 2) % NP);
      sb.push_back('{oh, (i > 0 && i % 2 == 0) ? 5'b00001 << ((i / 2 + NP - 1) % NP) : 5'b0});
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.grant !== e.g || bus.timeout !== e.t)
        begin errors++; $display("FAIL rotate[%0d] grant=%b timeout=%b want grant=%b timeout=%b", i, bus.grant, bus.timeout, e.g, e.t); end
    end
  endtask

  task automatic test_drop();
    do_reset();
    set_port(2, 3'd1, 12'd8);
    bus.req = 5'b00100;
    sb.push_back('{5'b00100, 5'b0});
    sb.push_back('{5'b10000, 5'b0});
    sb.push_back('{5'b10000, 5'b0});
    sb.push_back('{5'b0, 5'b0});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.grant !== e.g || bus.timeout !== e.t)
        begin errors++; $display("FAIL drop[%0d] grant=%b timeout=%b want grant=%b timeout=%b", i, bus.grant, bus.timeout, e.g, e.t); end
      if (i == 0) bus.req = 5'b10000;
      if (i == 2) bus.req = '0;
    end
  endtask

  task automatic test_mid_update();
    do_reset();
    set_port(3, 3'd1, 12'd10);
    bus.req = 5'b01000;
    for (int i = 0; i < 5; i++) sb.push_back('{5'b01000, 5'b0});
    sb.push_back('{5'b0, 5'b01000});
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.grant !== e.g || bus.timeout !== e.t)
        begin errors++; $display("FAIL mid_update[%0d] grant=%b timeout=%b want grant=%b timeout=%b", i, bus.grant, bus.timeout, e.g, e.t); end
      if (i == 0) set_port(3, 3'd0, 12'd10);
      if (i == 3) set_port(3, 3'd1, 12'd5);
      if (i == 4) set_port(3, 3'd0, 12'd0);
    end
    bus.req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 5'b00010;
    sb.push_back('{5'b00010, 5'b0});
    sb.push_back('{5'b00010, 5'b0});
    sb.push_back('{5'b0, 5'b0});
    sb.push_back('{5'b00001, 5'b0});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (bus.grant !== e.g || bus.timeout !== e.t)
        begin errors++; $display("FAIL reset_mid[%0d] grant=%b timeout=%b want grant=%b timeout=%b", i, bus.grant, bus.timeout, e.g, e.t); end
      if (i == 0) bus.req = '1;
      if (i == 1) rst_n = 1'b0;
      if (i == 2) rst_n = 1'b1;
    end
    bus.req = '0;
  endtask

  initial begin
    bus.req = '0;
    bus.flit_id = '0;
    bus.length = '0;
    #1;
    test_reset();
    test_unlimited();
    test_timeout();
    test_rotate();
    test_drop();
    test_mid_update();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
